// File: rtl/output_vc_scheduler.sv
// rtl/output_vc_scheduler.sv - output-port scheduler: per-VC wormhole locks, credit counters,
// round-robin over inputs within a VC and over eligible VCs on the link.
module output_vc_scheduler #(
   parameter int N_INPUTS     = 4,
   parameter int N_VC         = 3,
   parameter int CREDIT_DEPTH = 4,
   parameter int VC_W         = $clog2(N_VC),
   parameter int CW           = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic [N_VC*N_INPUTS-1:0] req_i,
   input  logic [N_INPUTS-1:0]      head_i,
   input  logic [N_INPUTS-1:0]      tail_i,
   input  logic                     link_ready_i,
   input  logic [N_VC-1:0]          credit_ret_i,
   output logic [N_VC*N_INPUTS-1:0] grant_o,
   output logic                     valid_o,
   output logic [VC_W-1:0]          vc_sel_o,
   output logic [N_VC-1:0]          lock_o,
   output logic [N_VC*CW-1:0]       credit_cnt_o,
   output logic                     err_o
);
   localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

   logic [N_VC-1:0][N_INPUTS-1:0] req_2d, cand, gnt;
   logic [N_VC-1:0]               locked_q, locked_d;
   logic [N_VC-1:0][IW-1:0]       owner_q, owner_d, ip_q, ip_d, win_in;
   logic [N_VC-1:0]               has_cand, elig;
   logic [VC_W-1:0]               vp_q, vp_d, win_vc;
   logic                          valid;
   logic [N_VC-1:0][CW-1:0]       credit_q, credit_d;
   logic                          err_q, err_d;

   assign req_2d = req_i;

   // A locked VC only listens to its owner; an idle VC only to head flits.
   always_comb begin
      cand = '0;
      for (int v = 0; v < N_VC; v++) begin
         for (int i = 0; i < N_INPUTS; i++) begin
            cand[v][i] = req_2d[v][i] &&
                         (locked_q[v] ? (owner_q[v] == IW'(i)) : head_i[i]);
         end
      end
   end

   always_comb begin
      int            idx;
      logic [IW-1:0] pos;
      idx      = 0;
      pos      = '0;
      win_in   = '0;
      has_cand = '0;
      elig     = '0;
      for (int v = 0; v < N_VC; v++) begin
         // Scan from lowest priority to highest so the last hit is the winner.
         for (int k = N_INPUTS - 1; k >= 0; k--) begin
            idx = int'(ip_q[v]) + k;
            if (idx >= N_INPUTS) idx = idx - N_INPUTS;
            pos = IW'(idx);
            if (cand[v][pos]) begin
               win_in[v]   = pos;
               has_cand[v] = 1'b1;
            end
         end
         elig[v] = has_cand[v] && (credit_q[v] != '0);
      end
   end

   always_comb begin
      int              idx;
      logic [VC_W-1:0] pos;
      idx    = 0;
      pos    = '0;
      win_vc = '0;
      valid  = 1'b0;
      for (int k = N_VC - 1; k >= 0; k--) begin
         idx = int'(vp_q) + k;
         if (idx >= N_VC) idx = idx - N_VC;
         pos = VC_W'(idx);
         if (elig[pos]) begin
            win_vc = pos;
            valid  = 1'b1;
         end
      end
      valid = valid && link_ready_i && arst;
   end

   always_comb begin
      gnt = '0;
      if (valid) gnt[win_vc][win_in[win_vc]] = 1'b1;
   end

   always_comb begin
      logic consume;
      consume  = 1'b0;
      locked_d = locked_q;
      owner_d  = owner_q;
      ip_d     = ip_q;
      vp_d     = vp_q;
      credit_d = credit_q;
      err_d    = err_q;
      if (valid) begin
         vp_d = (win_vc == VC_W'(N_VC - 1)) ? '0 : win_vc + VC_W'(1);
         if (!locked_q[win_vc]) begin
            ip_d[win_vc] = (win_in[win_vc] == IW'(N_INPUTS - 1)) ? '0
                                                                  : win_in[win_vc] + IW'(1);
            if (!tail_i[win_in[win_vc]]) begin
               locked_d[win_vc] = 1'b1;
               owner_d[win_vc]  = win_in[win_vc];
            end
         end else if (tail_i[win_in[win_vc]]) begin
            locked_d[win_vc] = 1'b0;
         end
      end
      // A return into a full counter is a downstream protocol error; the count holds.
      for (int v = 0; v < N_VC; v++) begin
         consume = valid && (win_vc == VC_W'(v));
         if (consume && !credit_ret_i[v]) begin
            credit_d[v] = credit_q[v] - CW'(1);
         end else if (!consume && credit_ret_i[v]) begin
            if (credit_q[v] == CW'(CREDIT_DEPTH)) err_d = 1'b1;
            else credit_d[v] = credit_q[v] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!arst) begin
         locked_q <= '0;
         owner_q  <= '0;
         ip_q     <= '0;
         vp_q     <= '0;
         err_q    <= 1'b0;
         for (int v = 0; v < N_VC; v++) credit_q[v] <= CW'(CREDIT_DEPTH);
      end else begin
         locked_q <= locked_d;
         owner_q  <= owner_d;
         ip_q     <= ip_d;
         vp_q     <= vp_d;
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end

   assign grant_o      = gnt;
   assign valid_o      = valid;
   assign vc_sel_o     = valid ? win_vc : '0;
   assign lock_o       = locked_q;
   assign credit_cnt_o = credit_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_output_vc_scheduler.sv
// tb/tb_output_vc_scheduler.sv - directed and randomized check of output_vc_scheduler
// against a behavioural model of the scheduling rules.
module tb_output_vc_scheduler;
   localparam int NI = 4;
   localparam int NV = 3;
   localparam int CD = 4;

   logic        clk = 1'b0;
   logic        arst;
   logic [11:0] req;
   logic [3:0]  head, tail;
   logic        lr;
   logic [2:0]  cret;
   logic [11:0] grant_o;
   logic        valid_o;
   logic [1:0]  vc_sel_o;
   logic [2:0]  lock_o;
   logic [8:0]  credit_cnt_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   int m_lock[NV];
   int m_ip[NV];
   int m_cred[NV];
   int m_vp;
   bit m_err;
   bit m_init = 1'b0;
   int cur_gv, cur_gi;

   output_vc_scheduler #(.N_INPUTS(NI), .N_VC(NV), .CREDIT_DEPTH(CD)) dut (
      .clk(clk), .arst(arst), .req_i(req), .head_i(head), .tail_i(tail),
      .link_ready_i(lr), .credit_ret_i(cret), .grant_o(grant_o), .valid_o(valid_o),
      .vc_sel_o(vc_sel_o), .lock_o(lock_o), .credit_cnt_o(credit_cnt_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic void model_pick(output int gv, output int gi);
      gv = -1;
      gi = -1;
      if (arst !== 1'b1 || lr !== 1'b1) return;
      for (int k = 0; k < NV; k++) begin
         int v;
         v = (m_vp + k) % NV;
         if (m_cred[v] > 0) begin
            for (int j = 0; j < NI; j++) begin
               int i;
               i = (m_ip[v] + j) % NI;
               if (req[v*NI+i] === 1'b1 &&
                   ((m_lock[v] >= 0) ? (i == m_lock[v]) : (head[i] === 1'b1))) begin
                  gv = v;
                  gi = i;
                  return;
               end
            end
         end
      end
   endfunction

   task automatic model_update();
      int gv, gi;
      if (arst === 1'b0) begin
         m_init = 1'b1;
         for (int v = 0; v < NV; v++) begin
            m_lock[v] = -1;
            m_ip[v]   = 0;
            m_cred[v] = CD;
         end
         m_vp  = 0;
         m_err = 1'b0;
      end else if (m_init) begin
         model_pick(gv, gi);
         for (int v = 0; v < NV; v++) begin
            bit cons, ret;
            cons = (gv == v);
            ret  = cret[v];
            if (cons && !ret) m_cred[v]--;
            else if (ret && !cons) begin
               if (m_cred[v] == CD) m_err = 1'b1;
               else m_cred[v]++;
            end
         end
         if (gv >= 0) begin
            m_vp = (gv + 1) % NV;
            if (m_lock[gv] < 0) begin
               m_ip[gv] = (gi + 1) % NI;
               if (!tail[gi]) m_lock[gv] = gi;
            end else if (tail[gi]) begin
               m_lock[gv] = -1;
            end
         end
      end
   endtask

   task automatic settle();
      logic [11:0] eg;
      logic [2:0]  el;
      logic [8:0]  ec;
      @(negedge clk);
      model_pick(cur_gv, cur_gi);
      if (m_init) begin
         eg = '0;
         if (cur_gv >= 0) eg[cur_gv*NI+cur_gi] = 1'b1;
         for (int v = 0; v < NV; v++) begin
            el[v]        = (m_lock[v] >= 0);
            ec[v*3 +: 3] = 3'(m_cred[v]);
         end
         chk("grant", grant_o, eg);
         chk("valid", valid_o, cur_gv >= 0);
         chk("vc_sel", vc_sel_o, (cur_gv >= 0) ? cur_gv : 0);
         chk("lock", lock_o, el);
         chk("credit", credit_cnt_o, ec);
         chk("err", err_o, m_err);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input logic [11:0] r, input logic [3:0] h, input logic [3:0] t,
                        input logic l, input logic [2:0] c);
      req = r; head = h; tail = t; lr = l; cret = c;
   endtask

   task automatic cyc(input logic [11:0] r, input logic [3:0] h, input logic [3:0] t,
                      input logic l, input logic [2:0] c);
      drive(r, h, t, l, c);
      settle();
      tick();
   endtask

   task automatic reset_dut();
      drive('0, '0, '0, 1'b1, '0);
      arst = 1'b0;
      settle();
      tick();
      arst = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog at %0t", $time);
      $fatal(1);
   end

   initial begin
      int n, s0, s1;
      logic [11:0] r;

      // Reset with every request asserted
      arst = 1'b0;
      drive('1, '1, '0, 1'b1, '0);
      settle();
      tick();
      settle();
      chk("rst_grant", grant_o, 12'h000);
      chk("rst_lock", lock_o, 3'b000);
      chk("rst_credit", credit_cnt_o, 9'h124);
      chk("rst_err", err_o, 1'b0);
      tick();
      arst = 1'b1;
      settle();
      chk("first_grant", grant_o, 12'h001);
      tick();

      // Wormhole lock on VC0: input1 3-flit packet, input2 waiting with a head
      reset_dut();
      drive(12'h006, 4'b0110, 4'b0000, 1'b1, '0);
      settle(); chk("wh_head", grant_o, 12'h002); tick();
      drive(12'h006, 4'b0100, 4'b0000, 1'b1, '0);
      settle(); chk("wh_lock_on", lock_o[0], 1'b1); chk("wh_body", grant_o, 12'h002); tick();
      drive(12'h006, 4'b0100, 4'b0010, 1'b1, '0);
      settle(); chk("wh_tail", grant_o, 12'h002); tick();
      drive(12'h004, 4'b0100, 4'b0000, 1'b1, '0);
      settle(); chk("wh_lock_off", lock_o[0], 1'b0); chk("wh_next", grant_o, 12'h004); tick();

      // Credit exhaustion on VC2
      reset_dut();
      n = 0;
      for (int k = 0; k < 6; k++) begin
         drive(12'h100, 4'b0001, 4'b0001, 1'b1, '0);
         settle();
         if (grant_o[8]) n++;
         tick();
      end
      chk("exh_count", n, 4);
      drive(12'h100, 4'b0001, 4'b0001, 1'b1, 3'b100);
      settle();
      chk("exh_cred", credit_cnt_o[8:6], 3'd0);
      chk("exh_grant", grant_o, 12'h000);
      tick();
      drive(12'h100, 4'b0001, 4'b0001, 1'b1, 3'b000);
      settle(); chk("ret_grant", grant_o, 12'h100); tick();

      // VC0 and VC1 packets interleaving at flit level
      reset_dut();
      s0 = 0; s1 = 0;
      for (int k = 0; k < 8; k++) begin
         r = '0;
         r[0] = (s0 < 4);
         r[5] = (s1 < 4);
         drive(r, {2'b00, s1 == 0, s0 == 0}, {2'b00, s1 == 3, s0 == 3}, 1'b1, '0);
         settle();
         chk("ilv_vcsel", vc_sel_o, k % 2);
         if (k == 4) chk("ilv_lock", lock_o, 3'b011);
         if (cur_gv == 0) s0++;
         if (cur_gv == 1) s1++;
         tick();
      end
      drive('0, '0, '0, 1'b1, '0);
      settle(); chk("ilv_unlock", lock_o, 3'b000); tick();

      // Simultaneous consume and return; overflow error
      reset_dut();
      cyc(12'h010, 4'b0001, 4'b0001, 1'b1, '0);
      cyc(12'h010, 4'b0001, 4'b0001, 1'b1, '0);
      cyc(12'h010, 4'b0001, 4'b0001, 1'b1, 3'b010);
      drive('0, '0, '0, 1'b1, 3'b001);
      settle(); chk("sim_cred", credit_cnt_o[5:3], 3'd2); tick();
      drive('0, '0, '0, 1'b1, '0);
      settle(); chk("ovf_err", err_o, 1'b1); chk("ovf_cred", credit_cnt_o[2:0], 3'd4); tick();
      cyc('0, '0, '0, 1'b1, '0);
      cyc('0, '0, '0, 1'b1, '0);
      settle(); chk("ovf_sticky", err_o, 1'b1); tick();

      // Backpressure, then reset in the middle of a packet
      reset_dut();
      cyc(12'h008, 4'b1000, 4'b0000, 1'b1, '0);
      for (int k = 0; k < 3; k++) begin
         drive(12'h008, 4'b0000, 4'b0000, 1'b0, '0);
         settle(); chk("bp_grant", grant_o, 12'h000); tick();
      end
      settle(); chk("bp_lock", lock_o, 3'b001); chk("bp_cred", credit_cnt_o[2:0], 3'd3); tick();
      arst = 1'b0;
      cyc(12'h008, 4'b0000, 4'b1000, 1'b1, 3'b001);
      arst = 1'b1;
      drive(12'h004, 4'b0100, 4'b0000, 1'b1, '0);
      settle(); chk("mid_lock", lock_o, 3'b000); chk("mid_head", grant_o, 12'h004); tick();

      // Randomized traffic with credits returned only for outstanding flits (rare spurious ones)
      reset_dut();
      for (int k = 0; k < 3000; k++) begin
         logic [2:0] c;
         arst = ($urandom_range(0, 299) != 0);
         for (int v = 0; v < NV; v++) begin
            c[v] = (m_cred[v] < CD) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 399) == 0);
         end
         drive(12'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 7) != 0, c);
         settle();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/output_vc_scheduler.md
# output_vc_scheduler

Control block for one router output port: decides each cycle which (virtual channel, input) pair may drive the output link, keeping wormhole packets intact per VC and never sending a flit without a downstream credit. It sits beside the output datapath mux and drives its select lines. It takes per-VC requests from the input modules and credit returns from the downstream router. It holds a per-VC packet lock, per-VC credit counters, and two levels of round-robin state.

## Interface
- N_INPUTS, 4, input modules competing for this output
- N_VC, 3, virtual channels on the link
- CREDIT_DEPTH, 4, downstream buffer slots per VC
- VC_W, derived = $clog2(N_VC) (2 for defaults); CW, derived = $clog2(CREDIT_DEPTH+1) (3 for defaults)

- clk  in  1  clock, all state on rising edge
- arst  in  1  reset, synchronous, active-low
- req_i  in  N_VC*N_INPUTS  bit [v*N_INPUTS+i]: input i has a flit for VC v
- head_i  in  N_INPUTS  flit offered by input i is a head flit
- tail_i  in  N_INPUTS  flit offered by input i is a tail flit (head+tail = single-flit packet)
- link_ready_i  in  1  output link accepts a flit this cycle
- credit_ret_i  in  N_VC  one pulse = one slot freed downstream in VC v
- grant_o  out  N_VC*N_INPUTS  one-hot or zero; flit transfers in the cycle it is high
- valid_o  out  1  OR of grant_o
- vc_sel_o  out  VC_W  VC of the granted flit; 0 when valid_o=0
- lock_o  out  N_VC  VC v has an open packet
- credit_cnt_o  out  N_VC*CW  credit counter per VC
- err_o  out  1  sticky: a credit was returned while the counter was full

## Operation
- Per-VC state is IDLE or LOCKED(owner). In IDLE, the candidates for VC v are inputs i with req_i[v*N+i] & head_i[i]. In LOCKED, the only candidate is the owner; head_i is ignored. Requests from non-owners wait.
- Input arbitration per VC is round-robin. Pointer ip[v] names the highest-priority input; the search goes ip[v], ip[v]+1, … mod N_INPUTS.
- A VC is eligible if it has a candidate and its credit is greater than 0.
- VC arbitration is round-robin over eligible VCs. Pointer vp names the highest-priority VC; the search goes vp, vp+1, … mod N_VC.
- grant_o, valid_o and vc_sel_o are combinational from current state plus req_i, head_i and link_ready_i. When link_ready_i=0, all three are 0.
- On a transfer of VC v from input i:
  - credit[v] decrements.
  - vp becomes (v+1) mod N_VC, so VCs interleave at flit level.
  - IDLE with head & !tail: go to LOCKED(i) and set ip[v] = (i+1) mod N.
  - IDLE with head & tail: stay IDLE and set ip[v] = (i+1) mod N.
  - LOCKED with tail: go to IDLE; ip[v] is unchanged.
  - LOCKED with !tail: stay LOCKED.
- Credit update, applied each cycle per VC:
  - consume only: -1
  - return only: +1
  - both: unchanged
  - return while at CREDIT_DEPTH with no consume: counter holds and err_o is set to 1 until reset.
  - A counter never goes below 0, because a VC at 0 is not eligible.
- A LOCKED VC whose owner drops its request stays LOCKED and is not granted. The lock ends only on a tail transfer.

## Timing
- Grant-to-transfer latency is 0: the flit moves in the cycle grant_o is high.
- State updates are visible the following cycle.
- Credit returned in cycle t makes the VC eligible in cycle t+1, not t.
- After a tail transfer in cycle t, a new head on that VC can be granted in cycle t+1.
- Reset (arst=0 at an edge) forces, next cycle:
  - all VCs IDLE, lock_o=0
  - credit=CREDIT_DEPTH for every VC
  - ip[v]=0 and vp=0
  - err_o=0
  - While arst=0, grant_o=0, valid_o=0 and vc_sel_o=0.
- Reset overrides any transfer, credit return or lock in the same cycle. An open packet is abandoned.

## Test plan
- Reset state: hold arst=0 for 2 cycles with all requests high. Required: grant_o=0, lock_o=000, every credit_cnt=4, err_o=0. On release, the first grant is VC0/input0 (grant_o bit 0).
- Wormhole lock: input1 sends a 3-flit packet on VC0 (head, body, tail) while input2 holds a VC0 head. Required: grant bit 1 for 3 consecutive cycles (VC1/VC2 idle); lock_o[0]=1 after the head and 0 after the tail; input2 granted in the 4th cycle.
- Credit exhaustion: VC2 only, 6 single-flit packets from input0, no returns. Required: exactly 4 grants, then credit_cnt[2]=0 and grant_o=0. A credit_ret_i[2] pulse yields one grant in the following cycle.
- VC interleave: VC0 and VC1 both have 4-flit packets open with link_ready=1. Required: vc_sel_o alternates 0,1,0,1…, and each lock is held until its own tail.
- Simultaneous consume and return: VC1 at credit 2, transfer plus credit_ret_i[1] in the same cycle. Required: credit stays 2. A return at credit 4 with no transfer gives credit 4 and err_o=1, held until reset.
- Backpressure and mid-packet reset:
  - link_ready_i=0 for 3 cycles. Required: grant_o=0 and state frozen.
  - arst pulse while VC0 is LOCKED. Required: lock_o[0]=0 and a new head from any input is accepted.
